// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Holds the FSM encoding and the word-address step used by the datapath.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHold,
    StRun
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'h0000_0000;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 2;

  localparam logic [31:0] WordBytes = 32'd4;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  function automatic logic [31:0] addr_next(input logic [31:0] addr);
    return addr + WordBytes;
  endfunction

endpackage

// File: rtl/imem_loader_dp.sv
// Loader datapath: write address, remaining word count and reset-hold counter.
// All three registers are steered by strobes from the loader FSM.
module imem_loader_dp
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BaseAddr   = BASE_ADDR_DEFAULT,
  parameter int unsigned HoldCycles = HOLD_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [7:0]  load_count_i,
  input  logic        advance_i,
  input  logic        hold_load_i,
  input  logic        hold_full_i,
  input  logic        hold_dec_i,
  output logic [31:0] addr_o,
  output logic        last_o,
  output logic        hold_zero_o
);

  // Entering HOLD from LOAD spends one extra HOLD cycle on the final write,
  // so the reset-low window after that write is exactly HoldCycles long.
  localparam logic [31:0] HoldFull  = 32'(HoldCycles);
  localparam logic [31:0] HoldShort = (HoldCycles == 0) ? 32'd0 : 32'(HoldCycles - 1);

  logic [31:0] addr_q, addr_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] hold_q, hold_d;

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    hold_d  = hold_q;

    if (load_i) begin
      addr_d  = BaseAddr;
      count_d = load_count_i;
    end else if (advance_i) begin
      addr_d  = addr_next(addr_q);
      count_d = count_q - 8'd1;
    end

    if (hold_load_i) begin
      hold_d = hold_full_i ? HoldFull : HoldShort;
    end else if (hold_dec_i && (hold_q != 32'd0)) begin
      hold_d = hold_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= BaseAddr;
      count_q <= 8'd0;
      hold_q  <= 32'd0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  assign addr_o      = addr_q;
  assign last_o      = (count_q == 8'd1);
  assign hold_zero_o = (hold_q == 32'd0);

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into instruction memory while holding the CPU in
// reset, then releases the CPU a fixed number of cycles after the last write.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  load_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        dp_load, dp_advance;
  logic        hold_load, hold_full, hold_dec;
  logic [31:0] dp_addr;
  logic        last_word, hold_zero;
  logic        restart;

  imem_loader_dp #(
    .BaseAddr  (BASE_ADDR),
    .HoldCycles(HOLD_CYCLES)
  ) u_dp (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (dp_load),
    .load_count_i(load_count),
    .advance_i   (dp_advance),
    .hold_load_i (hold_load),
    .hold_full_i (hold_full),
    .hold_dec_i  (hold_dec),
    .addr_o      (dp_addr),
    .last_o      (last_word),
    .hold_zero_o (hold_zero)
  );

  // A load in progress cannot be restarted; every other state honours start.
  assign restart = start && (state_q != StLoad);

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dp_load     = 1'b0;
    dp_advance  = 1'b0;
    hold_load   = 1'b0;
    hold_full   = 1'b0;
    hold_dec    = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (in_valid && in_ready_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = dp_addr;
          mem_wdata_d = in_data;
          dp_advance  = 1'b1;
          if (last_word) begin
            state_d   = StHold;
            hold_load = 1'b1;
            hold_full = 1'b1;
          end
        end
      end
      StHold: begin
        if (!restart) begin
          if (hold_zero) begin
            state_d = StRun;
          end else begin
            hold_dec = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (restart) begin
      if (load_count != 8'd0) begin
        state_d = StLoad;
        dp_load = 1'b1;
      end else begin
        state_d   = StHold;
        hold_load = 1'b1;
      end
    end

    // Outputs are registered from the next state so they align with state_q.
    in_ready_d  = (state_d == StLoad);
    cpu_rst_n_d = (state_d == StRun);
    busy_d      = (state_d == StLoad) || (state_d == StHold);
    done_d      = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base FFFF_FFFC) share stimulus;
// expected writes and release timing come from a queue-based model of the load rules.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BaseA = 32'h0000_0000;
  localparam logic [31:0] BaseB = 32'hFFFF_FFFC;
  localparam int unsigned Hold  = HOLD_CYCLES_DEFAULT;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  logic        clk, rst_n, start, in_valid;
  logic [7:0]  load_count;
  logic [31:0] in_data;
  logic        a_in_ready, a_mem_we, a_cpu_rst_n, a_busy, a_done;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic        b_in_ready, b_mem_we, b_cpu_rst_n, b_busy, b_done;
  logic [31:0] b_mem_addr, b_mem_wdata;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] prog [3];
  wr_t         act_a[$], act_b[$], exp_a[$], exp_b[$];

  imem_loader #(.BASE_ADDR(BaseA), .HOLD_CYCLES(Hold)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .load_count(load_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .cpu_rst_n(a_cpu_rst_n), .busy(a_busy), .done(a_done)
  );

  imem_loader #(.BASE_ADDR(BaseB), .HOLD_CYCLES(Hold)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .load_count(load_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_rst_n(b_cpu_rst_n), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (a_mem_we) act_a.push_back('{addr: a_mem_addr, data: a_mem_wdata, cyc: cyc});
    if (b_mem_we) act_b.push_back('{addr: b_mem_addr, data: b_mem_wdata, cyc: cyc});
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_in_ready_a"}, a_in_ready, 1'b0);
    check1({tag, "_mem_we_a"}, a_mem_we, 1'b0);
    check32({tag, "_mem_addr_a"}, a_mem_addr, BaseA);
    check32({tag, "_mem_wdata_a"}, a_mem_wdata, 32'd0);
    check1({tag, "_cpu_rst_n_a"}, a_cpu_rst_n, 1'b0);
    check1({tag, "_busy_a"}, a_busy, 1'b0);
    check1({tag, "_done_a"}, a_done, 1'b0);
    check1({tag, "_mem_we_b"}, b_mem_we, 1'b0);
    check32({tag, "_mem_addr_b"}, b_mem_addr, BaseB);
    check1({tag, "_cpu_rst_n_b"}, b_cpu_rst_n, 1'b0);
  endtask

  task automatic compare_writes(input string tag, input wr_t act[$], input wr_t exp[$]);
    check32({tag, "_write_count"}, 32'(act.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < act.size()) begin
        check32({tag, "_addr"}, act[i].addr, exp[i].addr);
        check32({tag, "_data"}, act[i].data, exp[i].data);
        check32({tag, "_cycle"}, act[i].cyc, exp[i].cyc);
      end
    end
  endtask

  // One complete load: start, n words with random idle gaps, then CPU release.
  task automatic run_load(input string tag, input int n, input int gap_lo, input int gap_hi,
                          input bit use_prog, input bit poke);
    logic [31:0] w;
    logic [31:0] t_ref;
    int          k;
    act_a.delete(); act_b.delete(); exp_a.delete(); exp_b.delete();
    start      = 1'b1;
    load_count = 8'(n);
    t_ref      = cyc;
    tick();
    start      = 1'b0;
    load_count = 8'($urandom);
    check1({tag, "_start_cpu_rst_n"}, a_cpu_rst_n, 1'b0);
    check1({tag, "_start_busy"}, b_busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      k = int'($urandom_range(gap_hi, gap_lo));
      in_valid = 1'b0;
      repeat (k) begin
        in_data = $urandom;
        tick();
      end
      w = (use_prog && i < 3) ? prog[i] : $urandom;
      in_valid = 1'b1;
      in_data  = w;
      if (poke && i == n / 2) begin
        start      = 1'b1;
        load_count = 8'($urandom_range(255, 1));
      end
      check1({tag, "_in_ready_a"}, a_in_ready, 1'b1);
      check1({tag, "_in_ready_b"}, b_in_ready, 1'b1);
      exp_a.push_back('{addr: BaseA + 32'(i) * 32'd4, data: w, cyc: cyc + 32'd1});
      exp_b.push_back('{addr: BaseB + 32'(i) * 32'd4, data: w, cyc: cyc + 32'd1});
      t_ref = cyc + 32'd1;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (n > 0) begin
      check1({tag, "_in_ready_drop_a"}, a_in_ready, 1'b0);
      check1({tag, "_in_ready_drop_b"}, b_in_ready, 1'b0);
    end
    for (int j = 0; j < 64 && a_cpu_rst_n !== 1'b1; j++) tick();
    check32({tag, "_release_delay"}, cyc - t_ref, 32'(Hold) + 32'd1);
    check1({tag, "_cpu_rst_n_b"}, b_cpu_rst_n, 1'b1);
    check1({tag, "_done_a"}, a_done, 1'b1);
    check1({tag, "_done_b"}, b_done, 1'b1);
    check1({tag, "_busy_run"}, a_busy, 1'b0);
    compare_writes({tag, "_a"}, act_a, exp_a);
    compare_writes({tag, "_b"}, act_b, exp_b);
  endtask

  task automatic reset_mid_load();
    act_a.delete(); act_b.delete();
    start      = 1'b1;
    load_count = 8'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = $urandom;
    tick();
    in_data = $urandom;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      check1("midreset_idle_in_ready", a_in_ready, 1'b0);
      check1("midreset_idle_busy", b_busy, 1'b0);
    end
    in_valid = 1'b0;
    check32("midreset_writes_a", 32'(act_a.size()), 32'd0);
    check32("midreset_writes_b", 32'(act_b.size()), 32'd0);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b1;
    start      = 1'b0;
    load_count = 8'd0;
    in_valid   = 1'b0;
    in_data    = 32'd0;
    prog[0]    = 32'h2008_0005;
    prog[1]    = 32'h2009_0007;
    prog[2]    = 32'h0109_5020;

    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    check1("idle_in_ready", a_in_ready, 1'b0);
    check1("idle_cpu_rst_n", a_cpu_rst_n, 1'b0);
    check1("idle_done", a_done, 1'b0);
    in_valid = 1'b0;

    run_load("prog3", 3, 0, 0, 1'b1, 1'b0);
    run_load("gap4", 2, 4, 4, 1'b0, 1'b0);
    run_load("zero", 0, 0, 0, 1'b0, 1'b0);
    run_load("rerun1", 1, 0, 0, 1'b0, 1'b0);
    reset_mid_load();
    run_load("wrap2", 2, 0, 0, 1'b0, 1'b0);
    run_load("ignore_start", 6, 0, 2, 1'b0, 1'b1);
    repeat (3) run_load("rand", int'($urandom_range(20, 1)), 0, 3, 1'b0, 1'b0);
    run_load("full255", 255, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
